// File: rtl/mini_cpu_ctrl_pkg.sv
// Shared encodings for the mini CPU multi-cycle control sequencer:
// state codes, opcodes, and datapath select codes.
package mini_cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_EXEC_R = 4'd2,
        ST_WB_R   = 4'd3,
        ST_EXEC_I = 4'd4,
        ST_WB_I   = 4'd5,
        ST_MEMADR = 4'd6,
        ST_MEMRD  = 4'd7,
        ST_WB_MEM = 4'd8,
        ST_MEMWR  = 4'd9,
        ST_BRANCH = 4'd10,
        ST_JUMP   = 4'd11,
        ST_HALT   = 4'd12
    } state_e;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    // ALU source-B select
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_ONE  = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_ZERO = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // ALU operation class
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/ctrl_opcode_decoder.sv
// Combinational opcode dispatch: picks the state that follows DECODE and
// flags loads so MEMADR can later choose between read and write.
module ctrl_opcode_decoder
    import mini_cpu_ctrl_pkg::*;
#(
    parameter int OPW = 6
) (
    input  logic [OPW-1:0] opcode_i,
    output state_e         next_state_o,
    output logic           is_load_o
);

    // Map opcode to dispatch target; unknown codes stop the machine in HALT
    always_comb begin
        next_state_o = ST_HALT;
        is_load_o    = 1'b0;
        case (opcode_i)
            OPW'(OP_RTYPE): next_state_o = ST_EXEC_R;
            OPW'(OP_ADDI):  next_state_o = ST_EXEC_I;
            OPW'(OP_LW): begin
                next_state_o = ST_MEMADR;
                is_load_o    = 1'b1;
            end
            OPW'(OP_SW):    next_state_o = ST_MEMADR;
            OPW'(OP_BEQ):   next_state_o = ST_BRANCH;
            OPW'(OP_J):     next_state_o = ST_JUMP;
            default:        next_state_o = ST_HALT;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control sequencer for the mini CPU datapath.
// Steps fetch/decode/execute/mem/writeback and drives all datapath strobes.
// Optional build macro CTRL_PERF_CNT_EN adds CYCLES/RETIRED counters.
module multicycle_ctrl_fsm
    import mini_cpu_ctrl_pkg::*;
#(
    parameter int OPW  = 6
`ifdef CTRL_PERF_CNT_EN
    ,
    parameter int CNTW = 32
`endif
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [OPW-1:0] OPCODE,
    input  logic           ZERO,
    input  logic           MEMREADY,
    output logic           MEMREQ,
    output logic           MEMWRITE,
    output logic           IORD,
    output logic           IRWRITE,
    output logic           PCWRITE,
    output logic [1:0]     PCSRC,
    output logic           ALUSRCA,
    output logic [1:0]     ALUSRCB,
    output logic [1:0]     ALUOP,
    output logic           REGWRITE,
    output logic           REGDST,
    output logic           MEMTOREG,
    output logic           HALTED
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [CNTW-1:0] CYCLES,
    output logic [CNTW-1:0] RETIRED
`endif
);

    state_e state_q, state_d;
    logic   is_load_q, is_load_d;
    state_e dec_next_s;
    logic   dec_is_load_s;

    ctrl_opcode_decoder #(.OPW(OPW)) u_dec (
        .opcode_i     (OPCODE),
        .next_state_o (dec_next_s),
        .is_load_o    (dec_is_load_s)
    );

    // State and load/store class registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            is_load_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            is_load_q <= is_load_d;
        end
    end

    // Next-state logic; memory states wait on MEMREADY, HALT is terminal
    always_comb begin
        state_d   = state_q;
        is_load_d = is_load_q;
        case (state_q)
            ST_FETCH:  state_d = MEMREADY ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                state_d   = dec_next_s;
                is_load_d = dec_is_load_s;
            end
            ST_EXEC_R: state_d = ST_WB_R;
            ST_WB_R:   state_d = ST_FETCH;
            ST_EXEC_I: state_d = ST_WB_I;
            ST_WB_I:   state_d = ST_FETCH;
            ST_MEMADR: state_d = is_load_q ? ST_MEMRD : ST_MEMWR;
            ST_MEMRD:  state_d = MEMREADY ? ST_WB_MEM : ST_MEMRD;
            ST_WB_MEM: state_d = ST_FETCH;
            ST_MEMWR:  state_d = MEMREADY ? ST_FETCH : ST_MEMWR;
            ST_BRANCH: state_d = ST_FETCH;
            ST_JUMP:   state_d = ST_FETCH;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_FETCH;
        endcase
    end

    // Moore output decode; FETCH strobes gated by MEMREADY, all forced low in reset
    always_comb begin
        MEMREQ   = 1'b0;
        MEMWRITE = 1'b0;
        IORD     = 1'b0;
        IRWRITE  = 1'b0;
        PCWRITE  = 1'b0;
        PCSRC    = PCSRC_ALU;
        ALUSRCA  = 1'b0;
        ALUSRCB  = SRCB_REG;
        ALUOP    = ALUOP_ADD;
        REGWRITE = 1'b0;
        REGDST   = 1'b0;
        MEMTOREG = 1'b0;
        HALTED   = 1'b0;
        if (reset) begin
            // an in-flight request is abandoned the moment reset asserts
            MEMREQ = 1'b0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    MEMREQ  = 1'b1;
                    ALUSRCB = SRCB_ONE;
                    IRWRITE = MEMREADY;
                    PCWRITE = MEMREADY;
                end
                ST_DECODE: ALUSRCB = SRCB_IMM;
                ST_EXEC_R: begin
                    ALUSRCA = 1'b1;
                    ALUOP   = ALUOP_FUNCT;
                end
                ST_WB_R: begin
                    REGWRITE = 1'b1;
                    REGDST   = 1'b1;
                end
                ST_EXEC_I, ST_MEMADR: begin
                    ALUSRCA = 1'b1;
                    ALUSRCB = SRCB_IMM;
                end
                ST_WB_I:   REGWRITE = 1'b1;
                ST_MEMRD: begin
                    MEMREQ = 1'b1;
                    IORD   = 1'b1;
                end
                ST_WB_MEM: begin
                    REGWRITE = 1'b1;
                    MEMTOREG = 1'b1;
                end
                ST_MEMWR: begin
                    MEMREQ   = 1'b1;
                    MEMWRITE = 1'b1;
                    IORD     = 1'b1;
                end
                ST_BRANCH: begin
                    ALUSRCA = 1'b1;
                    ALUOP   = ALUOP_SUB;
                    PCSRC   = PCSRC_ALUOUT;
                    PCWRITE = ZERO;
                end
                ST_JUMP: begin
                    PCSRC   = PCSRC_JUMP;
                    PCWRITE = 1'b1;
                end
                ST_HALT: begin
                    ALUSRCB = SRCB_ZERO;
                    HALTED  = 1'b1;
                end
                default: ALUSRCB = SRCB_REG;
            endcase
        end
    end

`ifdef CTRL_PERF_CNT_EN
    logic [CNTW-1:0] cycles_q;
    logic [CNTW-1:0] retired_q;

    // Cycle counter (frozen in HALT) and retire counter (each return to FETCH)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycles_q  <= '0;
            retired_q <= '0;
        end else begin
            if (state_q != ST_HALT) begin
                cycles_q <= cycles_q + CNTW'(1);
            end
            if ((state_q != ST_FETCH) && (state_d == ST_FETCH)) begin
                retired_q <= retired_q + CNTW'(1);
            end
        end
    end

    assign CYCLES  = cycles_q;
    assign RETIRED = retired_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed self-checking bench for multicycle_ctrl_fsm.
// Output vector bit order: MEMREQ MEMWRITE IORD IRWRITE PCWRITE PCSRC[1:0]
// ALUSRCA ALUSRCB[1:0] ALUOP[1:0] REGWRITE REGDST MEMTOREG HALTED.
module tb_multicycle_ctrl_fsm;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] OPCODE = 6'd0;
    logic       ZERO = 1'b0;
    logic       MEMREADY = 1'b0;
    logic       MEMREQ, MEMWRITE, IORD, IRWRITE, PCWRITE;
    logic [1:0] PCSRC, ALUSRCB, ALUOP;
    logic       ALUSRCA, REGWRITE, REGDST, MEMTOREG, HALTED;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] CYCLES, RETIRED;
`endif

    int checks = 0;
    int errors = 0;

    // expected output vectors per state
    localparam logic [15:0] V_RESET   = 16'h0000;
    localparam logic [15:0] V_FETCH_R = 16'h9840;
    localparam logic [15:0] V_FETCH_W = 16'h8040;
    localparam logic [15:0] V_DECODE  = 16'h0080;
    localparam logic [15:0] V_EXEC_R  = 16'h0120;
    localparam logic [15:0] V_WB_R    = 16'h000C;
    localparam logic [15:0] V_EXEC_I  = 16'h0180;
    localparam logic [15:0] V_WB_I    = 16'h0008;
    localparam logic [15:0] V_MEMRD   = 16'hA000;
    localparam logic [15:0] V_WB_MEM  = 16'h000A;
    localparam logic [15:0] V_MEMWR   = 16'hE000;
    localparam logic [15:0] V_BR_T    = 16'h0B10;
    localparam logic [15:0] V_BR_NT   = 16'h0310;
    localparam logic [15:0] V_JUMP    = 16'h0C00;
    localparam logic [15:0] V_HALT    = 16'h00C1;

    wire [15:0] outs_s = {MEMREQ, MEMWRITE, IORD, IRWRITE, PCWRITE, PCSRC,
                          ALUSRCA, ALUSRCB, ALUOP, REGWRITE, REGDST, MEMTOREG, HALTED};

    multicycle_ctrl_fsm dut (
        .clk      (clk),
        .reset    (reset),
        .OPCODE   (OPCODE),
        .ZERO     (ZERO),
        .MEMREADY (MEMREADY),
        .MEMREQ   (MEMREQ),
        .MEMWRITE (MEMWRITE),
        .IORD     (IORD),
        .IRWRITE  (IRWRITE),
        .PCWRITE  (PCWRITE),
        .PCSRC    (PCSRC),
        .ALUSRCA  (ALUSRCA),
        .ALUSRCB  (ALUSRCB),
        .ALUOP    (ALUOP),
        .REGWRITE (REGWRITE),
        .REGDST   (REGDST),
        .MEMTOREG (MEMTOREG),
        .HALTED   (HALTED)
`ifdef CTRL_PERF_CNT_EN
        ,
        .CYCLES   (CYCLES),
        .RETIRED  (RETIRED)
`endif
    );

    // 10-unit clock
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // drive inputs at a negedge, check settled outputs, advance to next negedge
    task automatic step(input string tag, input logic rdy, input logic z,
                        input logic [5:0] op, input logic [15:0] exp);
        MEMREADY = rdy;
        ZERO     = z;
        OPCODE   = op;
        #1;
        check_val(tag, {16'h0000, outs_s}, {16'h0000, exp});
        @(negedge clk);
    endtask

    // assert reset for one clock, check cleared outputs, release at a negedge
    task automatic do_reset();
        MEMREADY = 1'b0;
        reset    = 1'b1;
        #1;
        check_val("reset_outs", {16'h0000, outs_s}, {16'h0000, V_RESET});
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        // fetch waits, then R-type with ALUSRCB 01,10,00,00
        step("fetch_wait0", 1'b0, 1'b0, 6'b000000, V_FETCH_W);
        step("fetch_wait1", 1'b0, 1'b0, 6'b000000, V_FETCH_W);
        step("r_fetch",     1'b1, 1'b0, 6'b000000, V_FETCH_R);
        step("r_decode",    1'b1, 1'b0, 6'b000000, V_DECODE);
        step("r_exec",      1'b1, 1'b0, 6'b000000, V_EXEC_R);
        step("r_wb",        1'b1, 1'b0, 6'b000000, V_WB_R);

        // ADDI
        step("i_fetch",  1'b1, 1'b0, 6'b001000, V_FETCH_R);
        step("i_decode", 1'b1, 1'b0, 6'b001000, V_DECODE);
        step("i_exec",   1'b1, 1'b0, 6'b001000, V_EXEC_I);
        step("i_wb",     1'b1, 1'b0, 6'b001000, V_WB_I);

        // LW with three wait cycles in MEMRD
        step("lw_fetch",  1'b1, 1'b0, 6'b100011, V_FETCH_R);
        step("lw_decode", 1'b1, 1'b0, 6'b100011, V_DECODE);
        step("lw_memadr", 1'b1, 1'b0, 6'b100011, V_EXEC_I);
        for (int i = 0; i < 3; i++) step("lw_memrd_wait", 1'b0, 1'b0, 6'b100011, V_MEMRD);
        step("lw_memrd_done", 1'b1, 1'b0, 6'b100011, V_MEMRD);
        step("lw_wb",         1'b1, 1'b0, 6'b100011, V_WB_MEM);

        // SW with one wait cycle, opcode changed after DECODE must not matter
        step("sw_fetch",     1'b1, 1'b0, 6'b101011, V_FETCH_R);
        step("sw_decode",    1'b1, 1'b0, 6'b101011, V_DECODE);
        step("sw_memadr",    1'b1, 1'b0, 6'b100011, V_EXEC_I);
        step("sw_memwr_w",   1'b0, 1'b0, 6'b100011, V_MEMWR);
        step("sw_memwr",     1'b1, 1'b0, 6'b100011, V_MEMWR);

        // BEQ taken and not taken
        step("beq_t_fetch",  1'b1, 1'b1, 6'b000100, V_FETCH_R);
        step("beq_t_decode", 1'b1, 1'b1, 6'b000100, V_DECODE);
        step("beq_t_branch", 1'b1, 1'b1, 6'b000100, V_BR_T);
        step("beq_n_fetch",  1'b1, 1'b0, 6'b000100, V_FETCH_R);
        step("beq_n_decode", 1'b1, 1'b0, 6'b000100, V_DECODE);
        step("beq_n_branch", 1'b1, 1'b0, 6'b000100, V_BR_NT);
        step("beq_n_next",   1'b0, 1'b0, 6'b000010, V_FETCH_W);

        // J
        step("j_fetch",  1'b1, 1'b0, 6'b000010, V_FETCH_R);
        step("j_decode", 1'b1, 1'b0, 6'b000010, V_DECODE);
        step("j_jump",   1'b1, 1'b0, 6'b000010, V_JUMP);

        // reset in the middle of a load access
        step("rst_fetch",  1'b1, 1'b0, 6'b100011, V_FETCH_R);
        step("rst_decode", 1'b1, 1'b0, 6'b100011, V_DECODE);
        step("rst_memadr", 1'b1, 1'b0, 6'b100011, V_EXEC_I);
        step("rst_memrd",  1'b0, 1'b0, 6'b100011, V_MEMRD);
        #2 reset = 1'b1;
        #1 check_val("rst_async_drop", {16'h0000, outs_s}, {16'h0000, V_RESET});
        @(negedge clk);
        check_val("rst_hold", {16'h0000, outs_s}, {16'h0000, V_RESET});
        reset = 1'b0;
        step("rst_after_fetch", 1'b0, 1'b0, 6'b100011, V_FETCH_W);

        // HALT opcode: sticky for 20 cycles whatever the inputs
        step("halt_fetch",  1'b1, 1'b0, 6'b111111, V_FETCH_R);
        step("halt_decode", 1'b1, 1'b0, 6'b111111, V_DECODE);
        for (int i = 0; i < 20; i++) step("halt_hold", i[0], ~i[0], 6'b000000, V_HALT);
        do_reset();

        // unknown opcode also halts
        step("ill_fetch",  1'b1, 1'b0, 6'b010101, V_FETCH_R);
        step("ill_decode", 1'b1, 1'b0, 6'b010101, V_DECODE);
        for (int i = 0; i < 20; i++) step("ill_hold", 1'b1, 1'b1, 6'b001000, V_HALT);
        do_reset();

`ifdef CTRL_PERF_CNT_EN
        // three back-to-back R-type instructions
        for (int n = 0; n < 3; n++) begin
            step("perf_fetch",  1'b1, 1'b0, 6'b000000, V_FETCH_R);
            step("perf_decode", 1'b1, 1'b0, 6'b000000, V_DECODE);
            step("perf_exec",   1'b1, 1'b0, 6'b000000, V_EXEC_R);
            step("perf_wb",     1'b1, 1'b0, 6'b000000, V_WB_R);
        end
        #1;
        check_val("perf_cycles",  CYCLES,  32'd12);
        check_val("perf_retired", RETIRED, 32'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
